conv_window_3x3: RTL

Streaming 3x3 window generator that sits directly upstream of the multiply-accumulate stage. It accepts one raster-order pixel per accepted cycle and buffers the two previous image rows. For every fully interior 3x3 neighbourhood it emits a flattened 9-pixel window in the packed format the multiply-accumulate stage takes on its `in` port. Edges are not padded: only windows lying entirely inside the image are produced.

---
 rtl/conv_window_3x3_if.sv | 21 ++
 rtl/conv_window_3x3.sv | 86 ++++++++
 2 files changed

// File: rtl/conv_window_3x3_if.sv
// Pixel stream in, 3x3 window stream out, for the window generator.
// Valid-only transfer: in_valid marks a pixel taken on that edge, win_valid a window usable that cycle; no ready either way.
interface conv_window_3x3_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic [DATA_W-1:0]     in_pixel;
    logic                  win_valid;
    logic [9*DATA_W-1:0]   window;
    logic                  frame_done;

    modport master (
        output in_valid, in_pixel,
        input  win_valid, window, frame_done
    );

    modport slave (
        input  in_valid, in_pixel,
        output win_valid, window, frame_done
    );
endinterface

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift array,
// emitting only windows that lie entirely inside the image.
module conv_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_3x3_if.slave     bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_W-1:0]     lb0 [0:IMG_W-1];
    logic [DATA_W-1:0]     lb1 [0:IMG_W-1];
    logic [DATA_W-1:0]     win [0:2][0:2];
    logic [DATA_W-1:0]     new_col [0:2];
    logic [9*DATA_W-1:0]   nxt_window;
    logic                  emit;
    logic                  last_pix;

    assign new_col[0] = lb1[col];
    assign new_col[1] = lb0[col];
    assign new_col[2] = bus.in_pixel;

    // Windows whose left columns wrap across a row boundary, or that reach above row 0, are dropped.
    assign emit     = bus.in_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

    // Window as it will look after this pixel shifts in, top-left in the MSBs.
    always_comb begin
        nxt_window = '0;
        for (int r = 0; r < 3; r++) begin
            nxt_window[(8 - 3*r) * DATA_W +: DATA_W] = win[r][1];
            nxt_window[(7 - 3*r) * DATA_W +: DATA_W] = win[r][2];
            nxt_window[(6 - 3*r) * DATA_W +: DATA_W] = new_col[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.window     <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                    win[r][2] <= new_col[r];
                end
                if (emit) begin
                    bus.win_valid  <= 1'b1;
                    bus.window     <= nxt_window;
                    bus.frame_done <= last_pix;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Stale contents are harmless: no emitted window reads rows not yet written this frame.
    always_ff @(posedge clk) begin
        if (bus.in_valid && !rst) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.in_pixel;
        end
    end
endmodule
